// File: rtl/galaxian_pkg.sv
// galaxian_pkg: shared coordinate type, key codes and missile slot states
package galaxian_pkg;
  typedef logic [9:0] coord_t;
  localparam logic [7:0] KEY_SPACE = 8'h2c;
  typedef enum logic {IDLE, FLYING} slot_state_t;
endpackage

// File: rtl/missile_slot.sv
// missile_slot: one missile's IDLE/FLYING state and position
// Ports: frame_clk/Reset (async active-low), launch loads launch_x/launch_y,
//        hit retires a flying missile, x/y/active report the slot.
module missile_slot
  import galaxian_pkg::*;
#(
  parameter int STEP  = 6,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 287
) (
  input  logic   frame_clk,
  input  logic   Reset,
  input  logic   launch,
  input  logic   hit,
  input  coord_t launch_x,
  input  coord_t launch_y,
  output coord_t x,
  output coord_t y,
  output logic   active
);
  slot_state_t state;
  logic retire;
  // Bound test is done in int so the top limit never wraps below zero
  assign retire = state == FLYING && (hit || int'(y) < Y_MIN + STEP || int'(y) >= Y_MAX);
  assign active = state == FLYING;
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
    end else if (retire) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
    end else if (state == FLYING) begin
      y <= y - coord_t'(STEP);
    end else if (launch) begin
      state <= FLYING;
      x     <= launch_x;
      y     <= launch_y;
    end
  end
endmodule

// File: rtl/missile_pool.sv
// missile_pool: fire-key edge/autofire detection, cooldown and slot allocation
// Ports: frame_clk/Reset (async active-low), keycode (two key slots),
//        SHIPX/SHIPY ship position, hit per-slot retire request,
//        MISSILE_X/MISSILE_Y packed 10-bit positions, missile_active,
//        fire_pulse one frame per launch.
module missile_pool
  import galaxian_pkg::*;
#(
  parameter int N_MISSILES = 4,
  parameter int STEP       = 6,
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 287,
  parameter int COOLDOWN   = 8,
  parameter int AUTOFIRE   = 0
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic [15:0]             keycode,
  input  logic [9:0]              SHIPX,
  input  logic [9:0]              SHIPY,
  input  logic [N_MISSILES-1:0]   hit,
  output logic [10*N_MISSILES-1:0] MISSILE_X,
  output logic [10*N_MISSILES-1:0] MISSILE_Y,
  output logic [N_MISSILES-1:0]   missile_active,
  output logic                    fire_pulse
);
  localparam int CW = $clog2(COOLDOWN + 2);
  logic fire_now, key_prev, fire_req, launch;
  logic [CW-1:0] cooldown;
  logic [N_MISSILES-1:0] idle, grant;
  coord_t launch_x, launch_y;
  assign fire_now = keycode[7:0] == KEY_SPACE || keycode[15:8] == KEY_SPACE;
  assign fire_req = AUTOFIRE != 0 ? fire_now : fire_now && !key_prev;
  // Slots retiring this frame are still FLYING here, so they cannot be reused until next frame
  assign idle     = ~missile_active;
  assign grant    = idle & (~idle + 1'b1);
  assign launch   = fire_req && cooldown == '0 && |idle;
  assign launch_x = SHIPX - 10'd1;
  assign launch_y = SHIPY - 10'd3;
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      key_prev   <= 1'b0;
      cooldown   <= '0;
      fire_pulse <= 1'b0;
    end else begin
      key_prev   <= fire_now;
      fire_pulse <= launch;
      cooldown   <= launch ? CW'(COOLDOWN) : cooldown - CW'(cooldown != '0);
    end
  end
  for (genvar i = 0; i < N_MISSILES; i++) begin : g_slot
    missile_slot #(.STEP(STEP), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)) u_slot (
      .frame_clk(frame_clk),
      .Reset(Reset),
      .launch(launch && grant[i]),
      .hit(hit[i]),
      .launch_x(launch_x),
      .launch_y(launch_y),
      .x(MISSILE_X[10*i +: 10]),
      .y(MISSILE_Y[10*i +: 10]),
      .active(missile_active[i])
    );
  end
endmodule

// File: tb/tb_missile_pool.sv
// tb_missile_pool: scoreboard bench for the default and autofire/no-cooldown pools
module tb_missile_pool;
  logic frame_clk = 1'b0;
  logic Reset = 1'b0;
  logic [15:0] key_a = '0, key_b = '0;
  logic [9:0] shipx = '0, shipy = '0;
  logic [3:0] hit_a = '0, hit_b = '0;
  logic [39:0] xa, ya, xb, yb;
  logic [3:0] act_a, act_b;
  logic fire_a, fire_b;
  int checks = 0, failures = 0;
  typedef struct {int slot; int x; int y;} exp_t;
  exp_t qa[$], qb[$];
  exp_t ea, eb;

  always #5 frame_clk = ~frame_clk;

  missile_pool dut_a (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(key_a), .SHIPX(shipx), .SHIPY(shipy),
    .hit(hit_a), .MISSILE_X(xa), .MISSILE_Y(ya), .missile_active(act_a), .fire_pulse(fire_a)
  );
  missile_pool #(.COOLDOWN(0), .AUTOFIRE(1)) dut_b (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(key_b), .SHIPX(shipx), .SHIPY(shipy),
    .hit(hit_b), .MISSILE_X(xb), .MISSILE_Y(yb), .missile_active(act_b), .fire_pulse(fire_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int f10(input logic [39:0] v, input int i);
    return int'(v[10*i +: 10]);
  endfunction

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic push_a(input int s, input int x, input int y);
    exp_t e;
    e.slot = s; e.x = x; e.y = y;
    qa.push_back(e);
  endtask

  task automatic push_b(input int s, input int x, input int y);
    exp_t e;
    e.slot = s; e.x = x; e.y = y;
    qb.push_back(e);
  endtask

  always @(negedge frame_clk) begin
    if (fire_a) begin
      if (qa.size() == 0) chk("unexpected_launch_a", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("launch_a_active", int'(act_a[ea.slot]), 1);
        chk("launch_a_x", f10(xa, ea.slot), ea.x);
        chk("launch_a_y", f10(ya, ea.slot), ea.y);
      end
    end
    if (fire_b) begin
      if (qb.size() == 0) chk("unexpected_launch_b", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("launch_b_active", int'(act_b[eb.slot]), 1);
        chk("launch_b_x", f10(xb, eb.slot), eb.x);
        chk("launch_b_y", f10(yb, eb.slot), eb.y);
      end
    end
  end

  initial begin
    repeat (2) step();
    chk("rst_active_a", int'(act_a), 0);
    chk("rst_xy_a", int'(|{xa, ya}), 0);
    chk("rst_fire_a", int'(fire_a), 0);
    chk("rst_active_b", int'(act_b), 0);
    Reset = 1'b1;
    shipx = 10'd100; shipy = 10'd280;
    step();
    key_a = 16'h002c; push_a(0, 99, 277);
    step();
    chk("shot_pulse", int'(fire_a), 1);
    chk("shot_y0", f10(ya, 0), 277);
    key_a = '0;
    step();
    chk("shot_y1", f10(ya, 0), 271);
    chk("shot_pulse_low", int'(fire_a), 0);
    step();
    chk("shot_y2", f10(ya, 0), 265);
    chk("shot_x_hold", f10(xa, 0), 99);
    repeat (6) step();
    key_a = 16'h2c00; push_a(1, 99, 277);
    step();
    repeat (15) step();
    chk("held_one_launch", int'(act_a), 4'b0011);
    key_a = '0;
    step();
    for (int c = 0; c < 5; c++) begin
      key_a = 16'h002c;
      if (c == 0) push_a(2, 99, 277);
      if (c == 3) push_a(3, 99, 277);
      step(); step();
      key_a = '0;
      step(); step();
    end
    chk("toggle_all_active", int'(act_a), 4'b1111);
    chk("slot0_y7", f10(ya, 0), 7);
    step();
    chk("slot0_y1", f10(ya, 0), 1);
    step();
    chk("top_retire_active", int'(act_a), 4'b1110);
    chk("top_retire_y", f10(ya, 0), 0);
    #2 Reset = 1'b0;
    #1;
    chk("async_rst_active", int'(act_a), 0);
    chk("async_rst_xy", int'(|{xa, ya}), 0);
    chk("async_rst_fire", int'(fire_a), 0);
    #2 Reset = 1'b1;
    shipy = 10'd8; key_a = 16'h002c; push_a(0, 99, 5);
    step();
    chk("exit_y5", f10(ya, 0), 5);
    key_a = '0;
    step();
    chk("exit_active", int'(act_a[0]), 0);
    chk("exit_x", f10(xa, 0), 0);
    chk("exit_y_nowrap", f10(ya, 0), 0);
    shipx = 10'd200; shipy = 10'd200; key_b = 16'h002c;
    for (int s = 0; s < 4; s++) push_b(s, 199, 197);
    repeat (4) step();
    chk("pool_full", int'(act_b), 4'b1111);
    step();
    chk("pool_drop_fire", int'(fire_b), 0);
    hit_b = 4'b0100;
    step();
    chk("hit2_active", int'(act_b), 4'b1011);
    chk("hit2_x", f10(xb, 2), 0);
    chk("hit2_y", f10(yb, 2), 0);
    chk("b_slot0_y", f10(yb, 0), 167);
    hit_b = '0; push_b(2, 199, 197);
    step();
    chk("refill_slot2", int'(act_b), 4'b1111);
    hit_b = 4'b0001;
    step();
    chk("hit_launch_fire", int'(fire_b), 0);
    chk("hit_launch_active", int'(act_b), 4'b1110);
    hit_b = '0; push_b(0, 199, 197);
    step();
    key_b = '0;
    step();
    @(negedge frame_clk);
    #1;
    chk("queue_a_empty", qa.size(), 0);
    chk("queue_b_empty", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
